param_control_unit: RTL and testbench

PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

---
 rtl/param_control_unit.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_param_control_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_control_unit.sv
// param_control_unit: microcoded-style control FSM for a small accumulator CPU.
// Sequences fetch (F1/F2), decode (DEC) and up to three execute cycles
// (EX1..EX3). It drives the datapath strobes, the one-hot register write
// enable, the ALU opcode and the datapath source mux select.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin from IDLE / resume from HALT
//   z          : accumulator zero flag (JPNZ condition)
//   ir         : instruction register contents {operand, opcode}
//   mem_rdy    : memory access complete
//   acw..dmw   : datapath strobes (clac, acw, irw, pcw, pc_inc, drw, arw,
//                imr, dmr, dmw)
//   reg_we     : one-hot general register write enable
//   alu_op     : 0 PASS, 1 ADD, 2 SUB, 3 MUL
//   mux_sel    : 0..NREG-1 reg, NREG AC, NREG+1 DR, NREG+2 PC,
//                NREG+3 constant one, NREG+4 IR operand
//   finish     : in HALT
//   illegal    : HALT was entered on an undecodable instruction
//   busy       : executing (not IDLE, not HALT)
//   instr_cnt  : saturating retired-instruction count
module param_control_unit #(
    parameter int unsigned NREG  = 10,
    parameter int unsigned OPC_W = 8,
    parameter int unsigned IR_W  = 16,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned SEL_W = $clog2(NREG + 5)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             z,
    input  logic [IR_W-1:0]  ir,
    input  logic             mem_rdy,
    output logic             clac,
    output logic             acw,
    output logic             irw,
    output logic             pcw,
    output logic             pc_inc,
    output logic             drw,
    output logic             arw,
    output logic             imr,
    output logic             dmr,
    output logic             dmw,
    output logic [NREG-1:0]  reg_we,
    output logic [1:0]       alu_op,
    output logic [SEL_W-1:0] mux_sel,
    output logic             finish,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int unsigned OPR_W = IR_W - OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LOAD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_INAC = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_MVAC = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_COPY = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_STOR = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JPNZ = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_LODM = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_END  = OPC_W'(11);

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;
    localparam logic [1:0] ALU_MUL  = 2'd3;

    localparam logic [SEL_W-1:0] SEL_AC  = SEL_W'(NREG);
    localparam logic [SEL_W-1:0] SEL_DR  = SEL_W'(NREG + 1);
    localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(NREG + 2);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(NREG + 3);
    localparam logic [SEL_W-1:0] SEL_IRO = SEL_W'(NREG + 4);

    localparam logic [OPR_W-1:0] NREG_OPR = OPR_W'(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_DEC,
        S_EX1,
        S_EX2,
        S_EX3,
        S_HALT
    } state_t;

    state_t           state;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             legal;
    logic             retire;

    logic [OPC_W-1:0] opc;
    logic [OPR_W-1:0] opr;

    assign opc = ir[OPC_W-1:0];
    assign opr = ir[IR_W-1:OPC_W];

    // Opcode legality; register-operand instructions also need an in-range index.
    always_comb begin
        legal = 1'b1;
        if (opc > OP_END) begin
            legal = 1'b0;
        end else if ((opc == OP_MVAC || opc == OP_COPY || opc == OP_ADD ||
                      opc == OP_SUB  || opc == OP_MUL) && opr >= NREG_OPR) begin
            legal = 1'b0;
        end
    end

    // Final execute cycle of an instruction (END included).
    always_comb begin
        retire = 1'b0;
        case (state)
            S_EX1: retire = (opc != OP_LOAD) && (opc != OP_STOR);
            S_EX2: retire = 1'b0;
            S_EX3: retire = (opc == OP_LOAD) || mem_rdy;
            default: retire = 1'b0;
        endcase
    end

    // State register, illegal flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (retire && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) state <= S_F1;
                end
                S_F1: begin
                    state <= S_F2;
                end
                S_F2: begin
                    if (mem_rdy) state <= S_DEC;
                end
                S_DEC: begin
                    if (legal) begin
                        state <= S_EX1;
                    end else begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                S_EX1: begin
                    if (opc == OP_LOAD || opc == OP_STOR) begin
                        state <= S_EX2;
                    end else if (opc == OP_END) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_F1;
                    end
                end
                S_EX2: begin
                    // LOAD waits here for the data read; STOR stages DR in one cycle.
                    if (opc != OP_LOAD || mem_rdy) state <= S_EX3;
                end
                S_EX3: begin
                    if (retire) state <= S_F1;
                end
                S_HALT: begin
                    if (start) begin
                        state     <= S_F1;
                        illegal_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobe decode from state, latched ir and the memory/zero handshakes.
    // Everything is forced low while rst is asserted.
    always_comb begin
        clac    = 1'b0;
        acw     = 1'b0;
        irw     = 1'b0;
        pcw     = 1'b0;
        pc_inc  = 1'b0;
        drw     = 1'b0;
        arw     = 1'b0;
        imr     = 1'b0;
        dmr     = 1'b0;
        dmw     = 1'b0;
        reg_we  = '0;
        alu_op  = ALU_PASS;
        mux_sel = '0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    clac = start;
                end
                S_F1: begin
                    arw     = 1'b1;
                    mux_sel = SEL_PC;
                end
                S_F2: begin
                    imr = 1'b1;
                    if (mem_rdy) begin
                        irw    = 1'b1;
                        pc_inc = 1'b1;
                    end
                end
                S_EX1: begin
                    case (opc)
                        OP_INAC: begin
                            acw     = 1'b1;
                            alu_op  = ALU_ADD;
                            mux_sel = SEL_ONE;
                        end
                        OP_MVAC: begin
                            if (opr < NREG_OPR) reg_we = NREG'(1) << opr;
                            mux_sel = SEL_AC;
                        end
                        OP_COPY: begin
                            acw     = 1'b1;
                            mux_sel = SEL_W'(opr);
                        end
                        OP_ADD: begin
                            acw     = 1'b1;
                            alu_op  = ALU_ADD;
                            mux_sel = SEL_W'(opr);
                        end
                        OP_SUB: begin
                            acw     = 1'b1;
                            alu_op  = ALU_SUB;
                            mux_sel = SEL_W'(opr);
                        end
                        OP_MUL: begin
                            acw     = 1'b1;
                            alu_op  = ALU_MUL;
                            mux_sel = SEL_W'(opr);
                        end
                        OP_LODM: begin
                            acw     = 1'b1;
                            mux_sel = SEL_IRO;
                        end
                        OP_JPNZ: begin
                            if (!z) begin
                                pcw     = 1'b1;
                                mux_sel = SEL_IRO;
                            end
                        end
                        OP_LOAD, OP_STOR: begin
                            arw     = 1'b1;
                            mux_sel = SEL_IRO;
                        end
                        default: begin
                            // NOP and END drive nothing.
                        end
                    endcase
                end
                S_EX2: begin
                    if (opc == OP_LOAD) begin
                        dmr = 1'b1;
                        drw = mem_rdy;
                    end else begin
                        drw     = 1'b1;
                        mux_sel = SEL_AC;
                    end
                end
                S_EX3: begin
                    if (opc == OP_LOAD) begin
                        acw     = 1'b1;
                        mux_sel = SEL_DR;
                    end else begin
                        dmw = 1'b1;
                    end
                end
                default: begin
                    // DEC and HALT drive no strobes.
                end
            endcase
        end
    end

    // Status outputs: state/flag registers, held at zero during reset.
    assign finish    = !rst && (state == S_HALT);
    assign busy      = !rst && (state != S_IDLE) && (state != S_HALT);
    assign illegal   = !rst && illegal_q;
    assign instr_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_param_control_unit.sv
// Directed bench for param_control_unit. Each step drives inputs, pushes the
// expected outputs to a scoreboard queue, then pops and compares at the
// falling edge. A second instance with CNT_W=2 shares the inputs and must
// match the same expectations with a saturated counter.
module tb_param_control_unit;

    localparam int unsigned NREG  = 10;
    localparam int unsigned SEL_W = 4;

    localparam logic [9:0] S_CLAC = 10'h200;
    localparam logic [9:0] S_ACW  = 10'h100;
    localparam logic [9:0] S_IRW  = 10'h080;
    localparam logic [9:0] S_PCW  = 10'h040;
    localparam logic [9:0] S_PCI  = 10'h020;
    localparam logic [9:0] S_DRW  = 10'h010;
    localparam logic [9:0] S_ARW  = 10'h008;
    localparam logic [9:0] S_IMR  = 10'h004;
    localparam logic [9:0] S_DMR  = 10'h002;
    localparam logic [9:0] S_DMW  = 10'h001;

    localparam logic [3:0] SEL_AC  = 4'd10;
    localparam logic [3:0] SEL_DR  = 4'd11;
    localparam logic [3:0] SEL_PC  = 4'd12;
    localparam logic [3:0] SEL_ONE = 4'd13;
    localparam logic [3:0] SEL_IRO = 4'd14;

    typedef struct packed {
        logic [9:0]  stb;
        logic [9:0]  we;
        logic [1:0]  alu;
        logic [3:0]  sel;
        logic        fin;
        logic        ill;
        logic        bsy;
        logic [15:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        z;
    logic [15:0] ir;
    logic        mem_rdy;

    logic clac, acw, irw, pcw, pc_inc, drw, arw, imr, dmr, dmw;
    logic [NREG-1:0]  reg_we;
    logic [1:0]       alu_op;
    logic [SEL_W-1:0] mux_sel;
    logic             finish, illegal, busy;
    logic [15:0]      instr_cnt;

    logic clac2, acw2, irw2, pcw2, pc_inc2, drw2, arw2, imr2, dmr2, dmw2;
    logic [NREG-1:0]  reg_we2;
    logic [1:0]       alu_op2;
    logic [SEL_W-1:0] mux_sel2;
    logic             finish2, illegal2, busy2;
    logic [1:0]       instr_cnt2;

    param_control_unit #(.NREG(10), .OPC_W(8), .IR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .z(z), .ir(ir), .mem_rdy(mem_rdy),
        .clac(clac), .acw(acw), .irw(irw), .pcw(pcw), .pc_inc(pc_inc),
        .drw(drw), .arw(arw), .imr(imr), .dmr(dmr), .dmw(dmw),
        .reg_we(reg_we), .alu_op(alu_op), .mux_sel(mux_sel),
        .finish(finish), .illegal(illegal), .busy(busy), .instr_cnt(instr_cnt)
    );

    param_control_unit #(.NREG(10), .OPC_W(8), .IR_W(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .z(z), .ir(ir), .mem_rdy(mem_rdy),
        .clac(clac2), .acw(acw2), .irw(irw2), .pcw(pcw2), .pc_inc(pc_inc2),
        .drw(drw2), .arw(arw2), .imr(imr2), .dmr(dmr2), .dmw(dmw2),
        .reg_we(reg_we2), .alu_op(alu_op2), .mux_sel(mux_sel2),
        .finish(finish2), .illegal(illegal2), .busy(busy2), .instr_cnt(instr_cnt2)
    );

    obs_t obs, obs2;
    assign obs  = '{stb: {clac, acw, irw, pcw, pc_inc, drw, arw, imr, dmr, dmw},
                    we: reg_we, alu: alu_op, sel: mux_sel,
                    fin: finish, ill: illegal, bsy: busy, cnt: instr_cnt};
    assign obs2 = '{stb: {clac2, acw2, irw2, pcw2, pc_inc2, drw2, arw2, imr2, dmr2, dmw2},
                    we: reg_we2, alu: alu_op2, sel: mux_sel2,
                    fin: finish2, ill: illegal2, bsy: busy2, cnt: 16'(instr_cnt2)};

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    m_cnt = 0;

    // One clock of stimulus with its expected outputs for both instances.
    task automatic step(input string tag, input logic [9:0] stb, input logic [9:0] we,
                        input logic [1:0] alu, input logic [3:0] sel,
                        input logic fin, input logic ill, input logic bsy);
        obs_t  e;
        obs_t  x;
        obs_t  x2;
        string t;
        e = '{stb: stb, we: we, alu: alu, sel: sel, fin: fin, ill: ill, bsy: bsy,
              cnt: 16'(m_cnt)};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        x  = exp_q.pop_front();
        t  = tag_q.pop_front();
        x2 = x;
        x2.cnt = (m_cnt > 3) ? 16'd3 : 16'(m_cnt);
        n_vec++;
        assert (obs === x) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", t, obs, x);
        end
        n_vec++;
        assert (obs2 === x2) else begin
            n_err++;
            $error("FAIL %s_sat: observed %h expected %h", t, obs2, x2);
        end
        @(posedge clk);
        #1;
    endtask

    // F1, F2 (with memory wait cycles), DEC.
    task automatic fetch(input logic [15:0] instr, input int waits);
        ir      = instr;
        start   = 1'b0;
        mem_rdy = 1'b0;
        step("f1", S_ARW, '0, 2'd0, SEL_PC, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < waits; i++) begin
            start = 1'b1;
            step("f2_wait", S_IMR, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        start   = 1'b0;
        mem_rdy = 1'b1;
        step("f2", S_IMR | S_IRW | S_PCI, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        mem_rdy = 1'b0;
        step("dec", '0, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Single-cycle EX1 that retires the instruction.
    task automatic ex_last(input string tag, input logic [9:0] stb, input logic [9:0] we,
                           input logic [1:0] alu, input logic [3:0] sel);
        step(tag, stb, we, alu, sel, 1'b0, 1'b0, 1'b1);
        m_cnt++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; z = 1'b0; ir = 16'h0000; mem_rdy = 1'b1;
        @(posedge clk);
        #1;
        step("reset", '0, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step("reset_hold", '0, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; start = 1'b0; mem_rdy = 1'b0;
        step("idle", '0, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step("idle_start", S_CLAC, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        fetch(16'h0308, 0);
        ex_last("add_r3", S_ACW, '0, 2'd1, 4'd3);
        fetch(16'h0002, 0);
        ex_last("inac", S_ACW, '0, 2'd1, SEL_ONE);
        fetch(16'h0403, 0);
        ex_last("mvac_r4", '0, 10'h010, 2'd0, SEL_AC);
        fetch(16'h0904, 0);
        ex_last("copy_r9", S_ACW, '0, 2'd0, 4'd9);
        fetch(16'h0009, 0);
        ex_last("sub_r0", S_ACW, '0, 2'd2, 4'd0);
        fetch(16'h010A, 0);
        ex_last("mul_r1", S_ACW, '0, 2'd3, 4'd1);
        fetch(16'h5507, 0);
        ex_last("lodm", S_ACW, '0, 2'd0, SEL_IRO);
        z = 1'b1;
        fetch(16'h2006, 0);
        ex_last("jpnz_z1", '0, '0, 2'd0, 4'd0);
        z = 1'b0;
        fetch(16'h2006, 0);
        ex_last("jpnz_z0", S_PCW, '0, 2'd0, SEL_IRO);
        fetch(16'h0000, 2);
        ex_last("nop", '0, '0, 2'd0, 4'd0);

        // LOAD with three data-memory wait cycles.
        fetch(16'h4001, 0);
        step("load_ex1", S_ARW, '0, 2'd0, SEL_IRO, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("load_ex2_wait", S_DMR, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        mem_rdy = 1'b1;
        step("load_ex2_rdy", S_DMR | S_DRW, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        mem_rdy = 1'b0;
        ex_last("load_ex3", S_ACW, '0, 2'd0, SEL_DR);

        // STOR with one write wait cycle.
        fetch(16'h4105, 0);
        step("stor_ex1", S_ARW, '0, 2'd0, SEL_IRO, 1'b0, 1'b0, 1'b1);
        step("stor_ex2", S_DRW, '0, 2'd0, SEL_AC, 1'b0, 1'b0, 1'b1);
        step("stor_ex3_wait", S_DMW, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        mem_rdy = 1'b1;
        ex_last("stor_ex3_rdy", S_DMW, '0, 2'd0, 4'd0);

        fetch(16'h000B, 0);
        ex_last("end", '0, '0, 2'd0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step("halt", '0, '0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        end
        start = 1'b1;
        step("halt_start", '0, '0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);

        // MVAC with out-of-range register operand.
        fetch(16'h0C03, 0);
        step("illegal_opr", '0, '0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        step("illegal_start", '0, '0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);

        // First undefined opcode.
        fetch(16'h000C, 0);
        step("illegal_opc", '0, '0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        step("illegal_opc_start", '0, '0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);

        // Reset while STOR is waiting in EX3.
        fetch(16'h4105, 0);
        step("stor2_ex1", S_ARW, '0, 2'd0, SEL_IRO, 1'b0, 1'b0, 1'b1);
        step("stor2_ex2", S_DRW, '0, 2'd0, SEL_AC, 1'b0, 1'b0, 1'b1);
        step("stor2_ex3_wait", S_DMW, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; start = 1'b1; mem_rdy = 1'b1;
        m_cnt = 0;
        step("rst_mid_stor", '0, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; start = 1'b0; mem_rdy = 1'b0;
        step("idle_after_rst", '0, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step("idle_start2", S_CLAC, '0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        fetch(16'h0000, 0);
        ex_last("nop2", '0, '0, 2'd0, 4'd0);
        ir = 16'h0000;
        step("f1_after_nop2", S_ARW, '0, 2'd0, SEL_PC, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
